// File: rtl/window_layer.sv
// window_layer: image-window compositor for the LCD video path.
//
// Takes the display timing coordinates and strobes, decides whether the
// current pixel falls inside a scaled image window, issues a read address
// to an external video RAM (one-cycle registered read), and composites the
// returned pixel over a background pattern. Output is RGB565 with the
// timing strobes delayed to match the fixed 3-cycle pipeline latency.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   frame_start         one-cycle pulse that loads the cfg_* shadow registers
//   cfg_x0, cfg_y0      window origin
//   cfg_scale           log2 magnification (0..3)
//   cfg_bg_mode         0 solid, 1 gradient, 2 checker, 3 black
//   cfg_bg_color        RGB565 background colour
//   cfg_key_en, cfg_key transparency key enable / value
//   in_x, in_y          current pixel coordinates
//   in_den/hs/vs        timing strobes aligned with in_x/in_y
//   mem_addr            video RAM read address {row, col}
//   mem_data            video RAM read data, valid one cycle after mem_addr
//   out_rgb             RGB565 as {b, g, r}, zero outside active video
//   out_den/hs/vs       strobes delayed by 3 cycles
module window_layer #(
    parameter int XW       = 16,
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 6,
    parameter int DATA_W   = 9,
    parameter int FMT      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic [XW-1:0]                cfg_x0,
    input  logic [XW-1:0]                cfg_y0,
    input  logic [1:0]                   cfg_scale,
    input  logic [1:0]                   cfg_bg_mode,
    input  logic [15:0]                  cfg_bg_color,
    input  logic                         cfg_key_en,
    input  logic [DATA_W-1:0]            cfg_key,
    input  logic [XW-1:0]                in_x,
    input  logic [XW-1:0]                in_y,
    input  logic                         in_den,
    input  logic                         in_hs,
    input  logic                         in_vs,
    output logic [ROW_BITS+COL_BITS-1:0] mem_addr,
    input  logic [DATA_W-1:0]            mem_data,
    output logic [15:0]                  out_rgb,
    output logic                         out_den,
    output logic                         out_hs,
    output logic                         out_vs
);

    // Carried per pixel through stages 1 and 2:
    // {den, hs, vs, in_win, background, key_en, key}
    localparam int CW = 3 + 1 + 16 + 1 + DATA_W;

    // ---------------- shadow configuration ----------------
    logic [XW-1:0]     x0_reg, y0_reg;
    logic [1:0]        scale_reg, bg_mode_reg;
    logic [15:0]       bg_color_reg;
    logic              key_en_reg;
    logic [DATA_W-1:0] key_reg;

    // A pixel presented together with frame_start still sees the old values
    // because the load only takes effect after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_reg       <= '0;
            y0_reg       <= '0;
            scale_reg    <= '0;
            bg_mode_reg  <= '0;
            bg_color_reg <= '0;
            key_en_reg   <= 1'b0;
            key_reg      <= '0;
        end else if (frame_start) begin
            x0_reg       <= cfg_x0;
            y0_reg       <= cfg_y0;
            scale_reg    <= cfg_scale;
            bg_mode_reg  <= cfg_bg_mode;
            bg_color_reg <= cfg_bg_color;
            key_en_reg   <= cfg_key_en;
            key_reg      <= cfg_key;
        end
    end

    // ---------------- stage 0: window test and address ----------------
    // One extra bit keeps x0 + width from wrapping, so a window that runs
    // past the top of the coordinate range is clipped rather than wrapped.
    logic [XW:0] x_w, y_w, x_lo, y_lo, x_hi, y_hi;
    logic        in_win;
    logic [XW-1:0] rel_x, rel_y;
    logic [COL_BITS-1:0] col_next;
    logic [ROW_BITS-1:0] row_next;

    assign x_w  = {1'b0, in_x};
    assign y_w  = {1'b0, in_y};
    assign x_lo = {1'b0, x0_reg};
    assign y_lo = {1'b0, y0_reg};
    assign x_hi = x_lo + ((XW+1)'(2**COL_BITS) << scale_reg);
    assign y_hi = y_lo + ((XW+1)'(2**ROW_BITS) << scale_reg);

    assign in_win = in_den && (x_w >= x_lo) && (x_w < x_hi)
                           && (y_w >= y_lo) && (y_w < y_hi);

    assign rel_x    = in_x - x0_reg;
    assign rel_y    = in_y - y0_reg;
    assign col_next = COL_BITS'(rel_x >> scale_reg);
    assign row_next = ROW_BITS'(rel_y >> scale_reg);

    // Address only moves for window pixels; it holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
        end else if (in_win) begin
            mem_addr <= {row_next, col_next};
        end
    end

    // Background pattern from the live coordinates.
    logic [15:0] bg_next;
    always_comb begin
        bg_next = '0;
        case (bg_mode_reg)
            2'd0:    bg_next = bg_color_reg;
            2'd1:    bg_next = 16'(x_w + y_w);
            2'd2:    bg_next = (in_x[3] ^ in_y[3]) ? bg_color_reg : ~bg_color_reg;
            default: bg_next = '0;
        endcase
    end

    // ---------------- stages 1 and 2: carry pixel context ----------------
    // The key travels with the pixel so a mid-line frame_start never mixes
    // old window decisions with a new key.
    logic [CW-1:0] stage_in;
    assign stage_in = {in_den, in_hs, in_vs, in_win, bg_next, key_en_reg, key_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stage
            logic [CW-1:0] stage_reg;
            logic [CW-1:0] stage_next;
            if (gi == 0) begin : g_head
                assign stage_next = stage_in;
            end else begin : g_tail
                assign stage_next = g_stage[gi-1].stage_reg;
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_next;
                end
            end
        end
    endgenerate

    // ---------------- stage 3: expand and composite ----------------
    logic              s_den, s_hs, s_vs, s_win, s_key_en;
    logic [15:0]       s_bg;
    logic [DATA_W-1:0] s_key;
    assign {s_den, s_hs, s_vs, s_win, s_bg, s_key_en, s_key} = g_stage[1].stage_reg;

    logic [4:0] pix_r, pix_b;
    logic [5:0] pix_g;
    generate
        if (FMT == 1) begin : g_rgb333
            // Replicate the top bits so full-scale 3-bit maps to full-scale.
            assign pix_r = {mem_data[8:6], mem_data[8:7]};
            assign pix_g = {mem_data[5:3], mem_data[5:3]};
            assign pix_b = {mem_data[2:0], mem_data[2:1]};
        end else begin : g_gray
            assign pix_r = mem_data[DATA_W-1 -: 5];
            assign pix_g = mem_data[DATA_W-1 -: 6];
            assign pix_b = mem_data[DATA_W-1 -: 5];
        end
    endgenerate

    logic        keyed;
    logic [15:0] rgb_next;
    always_comb begin
        keyed    = s_key_en && (mem_data == s_key);
        rgb_next = '0;
        if (s_den) begin
            rgb_next = (s_win && !keyed) ? {pix_b, pix_g, pix_r} : s_bg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_rgb <= '0;
            out_den <= 1'b0;
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
        end else begin
            out_rgb <= rgb_next;
            out_den <= s_den;
            out_hs  <= s_hs;
            out_vs  <= s_vs;
        end
    end

endmodule

// File: tb/tb_window_layer.sv
// Bench for window_layer: two instances (grayscale and RGB333) share all
// stimulus; each has its own registered-read video RAM model. Expected
// responses come from a coordinate-level reference model and are queued;
// a negedge monitor pops and compares them as the DUT outputs appear.
module tb_window_layer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, frame_start = 1'b0;
    logic [15:0] cfg_x0 = '0, cfg_y0 = '0, cfg_bg_color = '0;
    logic [1:0]  cfg_scale = '0, cfg_bg_mode = '0;
    logic        cfg_key_en = 1'b0;
    logic [8:0]  cfg_key = '0;
    logic [15:0] in_x = '0, in_y = '0;
    logic        in_den = 1'b0, in_hs = 1'b0, in_vs = 1'b0;

    logic [11:0] addr0, addr1;
    logic [8:0]  md0, md1;
    logic [15:0] rgb0, rgb1;
    logic        den0, hs0, vs0, den1, hs1, vs1;

    logic [8:0] ram [4096];
    always @(posedge clk) begin
        md0 <= ram[addr0];
        md1 <= ram[addr1];
    end

    window_layer #(.XW(16), .COL_BITS(6), .ROW_BITS(6), .DATA_W(9), .FMT(0)) u_gray (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_scale(cfg_scale),
        .cfg_bg_mode(cfg_bg_mode), .cfg_bg_color(cfg_bg_color),
        .cfg_key_en(cfg_key_en), .cfg_key(cfg_key),
        .in_x(in_x), .in_y(in_y), .in_den(in_den), .in_hs(in_hs), .in_vs(in_vs),
        .mem_addr(addr0), .mem_data(md0),
        .out_rgb(rgb0), .out_den(den0), .out_hs(hs0), .out_vs(vs0));

    window_layer #(.XW(16), .COL_BITS(6), .ROW_BITS(6), .DATA_W(9), .FMT(1)) u_rgb (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_scale(cfg_scale),
        .cfg_bg_mode(cfg_bg_mode), .cfg_bg_color(cfg_bg_color),
        .cfg_key_en(cfg_key_en), .cfg_key(cfg_key),
        .in_x(in_x), .in_y(in_y), .in_den(in_den), .in_hs(in_hs), .in_vs(in_vs),
        .mem_addr(addr1), .mem_data(md1),
        .out_rgb(rgb1), .out_den(den1), .out_hs(hs1), .out_vs(vs1));

    typedef struct { int cyc; logic [11:0] a; } aexp_t;
    typedef struct {
        int cyc; logic [2:0] st; logic [15:0] r0; logic [15:0] r1;
        logic kc; logic [15:0] k0; logic [15:0] k1;
    } oexp_t;
    aexp_t addr_q[$];
    oexp_t out_q[$];

    int total = 0, bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference shadow state
    int m_x0 = 0, m_y0 = 0, m_sc = 0, m_bm = 0, m_addr = 0;
    logic [15:0] m_bgc = '0;
    logic m_ke = 1'b0;
    logic [8:0] m_key = '0;
    // pending configuration presented on the cfg_* pins
    int p_x0 = 0, p_y0 = 0, p_sc = 0, p_bm = 0;
    logic [15:0] p_bgc = '0;
    logic p_ke = 1'b0;
    logic [8:0] p_key = '0;
    logic rst_v = 1'b1;

    function automatic logic [15:0] gray565(input logic [8:0] d);
        int r5, g6;
        r5 = int'(d) >> 4;
        g6 = int'(d) >> 3;
        return 16'((r5 << 11) | (g6 << 5) | r5);
    endfunction

    function automatic logic [15:0] rgb333(input logic [8:0] d);
        int r3, g3, b3, r5, g6, b5;
        r3 = (int'(d) >> 6) & 7;
        g3 = (int'(d) >> 3) & 7;
        b3 = int'(d) & 7;
        r5 = (r3 << 2) | (r3 >> 1);
        g6 = (g3 << 3) | g3;
        b5 = (b3 << 2) | (b3 >> 1);
        return 16'((b5 << 11) | (g6 << 5) | r5);
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic set_cfg(input int x0, input int y0, input int sc, input int bm,
                           input logic [15:0] bgc, input logic ke, input logic [8:0] key);
        p_x0 = x0; p_y0 = y0; p_sc = sc; p_bm = bm; p_bgc = bgc; p_ke = ke; p_key = key;
    endtask

    // Drive one pixel and queue its expected response.
    task automatic step(input logic fs, input int x, input int y, input logic den,
                        input logic kc, input logic [15:0] k0, input logic [15:0] k1);
        int xx, yy, w, h;
        logic win;
        logic [15:0] bg, px0, px1;
        logic [8:0] d;
        oexp_t oe;
        aexp_t ae;
        xx = x & 32'hFFFF;
        yy = y & 32'hFFFF;
        @(posedge clk);
        #1;
        rst = rst_v; frame_start = fs;
        cfg_x0 = 16'(p_x0); cfg_y0 = 16'(p_y0); cfg_scale = 2'(p_sc);
        cfg_bg_mode = 2'(p_bm); cfg_bg_color = p_bgc; cfg_key_en = p_ke; cfg_key = p_key;
        in_x = 16'(xx); in_y = 16'(yy); in_den = den;
        in_hs = 1'($urandom); in_vs = 1'($urandom);

        w = 64 << m_sc;
        h = 64 << m_sc;
        win = den && xx >= m_x0 && xx < m_x0 + w && yy >= m_y0 && yy < m_y0 + h;
        case (m_bm)
            0: bg = m_bgc;
            1: bg = 16'(xx + yy);
            2: bg = (((xx >> 3) ^ (yy >> 3)) & 1) != 0 ? m_bgc : ~m_bgc;
            default: bg = 16'h0000;
        endcase
        if (win) m_addr = (((yy - m_y0) >> m_sc) % 64) * 64 + (((xx - m_x0) >> m_sc) % 64);
        if (rst_v) m_addr = 0;
        ae.cyc = cyc; ae.a = 12'(m_addr);
        addr_q.push_back(ae);

        d = ram[m_addr];
        if (win && !(m_ke && d == m_key)) begin
            px0 = gray565(d); px1 = rgb333(d);
        end else begin
            px0 = bg; px1 = bg;
        end
        if (!den) begin px0 = '0; px1 = '0; end
        oe.cyc = cyc; oe.st = {den, in_hs, in_vs}; oe.r0 = px0; oe.r1 = px1;
        oe.kc = kc; oe.k0 = k0; oe.k1 = k1;
        out_q.push_back(oe);

        // A reset edge clears every pixel still inside the pipeline.
        if (rst_v) begin
            foreach (out_q[i]) begin
                if (out_q[i].cyc >= cyc - 2) begin
                    out_q[i].st = '0; out_q[i].r0 = '0; out_q[i].r1 = '0;
                    out_q[i].k0 = '0; out_q[i].k1 = '0;
                end
            end
            m_x0 = 0; m_y0 = 0; m_sc = 0; m_bm = 0; m_bgc = '0; m_ke = 1'b0; m_key = '0;
        end else if (fs) begin
            m_x0 = p_x0; m_y0 = p_y0; m_sc = p_sc; m_bm = p_bm;
            m_bgc = p_bgc; m_ke = p_ke; m_key = p_key;
        end
    endtask

    // Monitor: compare each queued expectation when its cycle comes up.
    always @(negedge clk) begin
        aexp_t ae;
        oexp_t oe;
        if (addr_q.size() > 0 && addr_q[0].cyc + 1 == cyc) begin
            ae = addr_q.pop_front();
            check("mem_addr_gray", {4'b0, addr0}, {4'b0, ae.a});
            check("mem_addr_rgb", {4'b0, addr1}, {4'b0, ae.a});
        end
        if (out_q.size() > 0 && out_q[0].cyc + 3 == cyc) begin
            oe = out_q.pop_front();
            check("strobes_gray", {13'b0, den0, hs0, vs0}, {13'b0, oe.st});
            check("strobes_rgb", {13'b0, den1, hs1, vs1}, {13'b0, oe.st});
            check("rgb_gray", rgb0, oe.r0);
            check("rgb_rgb333", rgb1, oe.r1);
            if (oe.kc) begin
                check("fixed_gray", rgb0, oe.k0);
                check("fixed_rgb333", rgb1, oe.k1);
            end
        end
    end

    initial begin
        int x, y;
        for (int i = 0; i < 4096; i++) ram[i] = 9'($urandom);
        ram[0] = 9'h1FF;
        ram[1] = 9'h1C0;
        ram[2] = 9'h000;

        // reset with active video present
        rst_v = 1'b1;
        repeat (4) step(1'b0, 10, 10, 1'b1, 1'b1, 16'h0000, 16'h0000);
        rst_v = 1'b0;
        repeat (4) step(1'b0, 10, 10, 1'b1, 1'b0, 16'h0, 16'h0);

        // latency and address scaling
        set_cfg(16, 16, 2, 0, 16'h0841, 1'b0, 9'h000);
        step(1'b1, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 16, 16, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        step(1'b0, 20, 16, 1'b1, 1'b1, 16'hE71C, 16'h001F);
        step(1'b0, 19, 16, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        // right window edge
        step(1'b0, 271, 16, 1'b1, 1'b0, 16'h0, 16'h0);
        step(1'b0, 272, 16, 1'b1, 1'b1, 16'h0841, 16'h0841);

        // background modes outside the window
        set_cfg(16, 16, 2, 1, 16'h0841, 1'b0, 9'h000);
        step(1'b1, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 3, 5, 1'b1, 1'b1, 16'h0008, 16'h0008);
        set_cfg(16, 16, 2, 2, 16'h001F, 1'b0, 9'h000);
        step(1'b1, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 8, 0, 1'b1, 1'b1, 16'h001F, 16'h001F);
        step(1'b0, 8, 8, 1'b1, 1'b1, 16'hFFE0, 16'hFFE0);
        set_cfg(16, 16, 2, 3, 16'h001F, 1'b0, 9'h000);
        step(1'b1, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 3, 5, 1'b1, 1'b1, 16'h0000, 16'h0000);

        // transparency key
        set_cfg(16, 16, 0, 0, 16'h1234, 1'b1, 9'h000);
        step(1'b1, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 18, 16, 1'b1, 1'b1, 16'h1234, 16'h1234);
        step(1'b0, 17, 16, 1'b1, 1'b1, 16'hE71C, 16'h001F);

        // window clipped at the top of the coordinate range
        set_cfg(16'hFFF0, 0, 3, 0, 16'h5555, 1'b0, 9'h000);
        step(1'b1, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 16; i++) step(1'b0, i, 0, 1'b1, 1'b1, 16'h5555, 16'h5555);
        step(1'b0, 16'hFFF0, 0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        step(1'b0, 16'hFFFF, 0, 1'b1, 1'b1, 16'hE71C, 16'h001F);

        // shadow timing
        set_cfg(16, 16, 0, 0, 16'h0F0F, 1'b0, 9'h000);
        step(1'b1, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        p_x0 = 100;
        step(1'b0, 16, 16, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        step(1'b1, 16, 16, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        step(1'b0, 16, 16, 1'b1, 1'b1, 16'h0F0F, 16'h0F0F);

        // reset mid-frame
        rst_v = 1'b1;
        repeat (2) step(1'b0, 5, 5, 1'b1, 1'b1, 16'h0000, 16'h0000);
        rst_v = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_v = ($urandom_range(0, 499) == 0);
            p_x0 = ($urandom_range(0, 7) == 0) ? 32'hFF00 + int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 300));
            p_y0 = int'($urandom_range(0, 300));
            p_sc = int'($urandom_range(0, 3));
            p_bm = int'($urandom_range(0, 3));
            p_bgc = 16'($urandom);
            p_ke = 1'($urandom);
            p_key = ($urandom_range(0, 1) == 1) ? ram[m_addr] : 9'($urandom);
            x = m_x0 + int'($urandom_range(0, (64 << m_sc) + 40)) - 20;
            y = m_y0 + int'($urandom_range(0, (64 << m_sc) + 40)) - 20;
            step(($urandom_range(0, 39) == 0), x, y, ($urandom_range(0, 7) != 0),
                 1'b0, 16'h0, 16'h0);
        end

        rst_v = 1'b0;
        repeat (4) step(1'b0, 0, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 10 && (out_q.size() > 0 || addr_q.size() > 0); i++) @(posedge clk);
        total++;
        if (out_q.size() > 0 || addr_q.size() > 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", out_q.size() + addr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/window_layer.md
# window_layer

Parametrised, pipelined image-window compositor for the LCD video path. It takes the display timing counters and sync/enable strobes and computes a scaled read address into a single-port-read video RAM. It then composites the returned pixel over a selectable background pattern and emits RGB565 with sync/enable delayed to match. It sits between the display timing generator and the LCD pins, and replaces hard-wired window, scale and colour-expansion logic with frame-synchronous runtime configuration.

## Interface
- XW, 16: width of x/y timing coordinates.
- COL_BITS, 6: log2 of image columns.
- ROW_BITS, 6: log2 of image rows.
- DATA_W, 9: video RAM word width; must be ≥ 6, and = 9 when FMT = 1.
- FMT, 0: pixel format. 0 = grayscale, 1 = RGB333.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; loads the cfg_* shadow registers.
- cfg_x0, cfg_y0  in  XW each  window origin.
- cfg_scale  in  2  log2 magnification, 0..3.
- cfg_bg_mode  in  2  background: 0 solid, 1 gradient, 2 checker, 3 black.
- cfg_bg_color  in  16  RGB565 background colour.
- cfg_key_en  in  1  transparency key enable.
- cfg_key  in  DATA_W  transparent pixel value.
- in_x, in_y  in  XW each  current pixel coordinates.
- in_den, in_hs, in_vs  in  1 each  timing strobes, aligned with in_x/in_y.
- mem_addr  out  ROW_BITS+COL_BITS  registered read address; concatenation {row, col}.
- mem_data  in  DATA_W  RAM read data; valid one cycle after mem_addr is presented.
- out_rgb  out  16  RGB565 as {b[15:11], g[10:5], r[4:0]}.
- out_den, out_hs, out_vs  out  1 each  delayed strobes.

## Operation
- Shadow registers:
  - Hold x0, y0, scale, bg_mode, bg_color, key_en and key.
  - Loaded only in a cycle with frame_start = 1.
  - A pixel presented in that same cycle still uses the old values.
- Window test, done in XW+1 bits so there is no wrap:
  - in_win = den and (x ≥ x0) and (x < x0 + (2^COL_BITS << scale)) and (y ≥ y0) and (y < y0 + (2^ROW_BITS << scale)).
  - A window extending past 2^XW is clipped, never wrapped.
- Address:
  - rel_x = x − x0, rel_y = y − y0.
  - mem_addr = {(rel_y >> scale)[ROW_BITS-1:0], (rel_x >> scale)[COL_BITS-1:0]}.
  - Updated only when in_win; otherwise mem_addr holds its value.
- Background, computed from the stage-0 x/y and carried down the pipeline:
  - mode 0: bg_color.
  - mode 1: (x + y) truncated to 16 bits.
  - mode 2: (x[3] ^ y[3]) ? bg_color : ~bg_color.
  - mode 3: 0.
- Pixel expansion:
  - FMT 0: r = d[DATA_W-1 -: 5], g = d[DATA_W-1 -: 6], b = d[DATA_W-1 -: 5].
  - FMT 1: r = {d[8:6], d[8:7]}, g = {d[5:3], d[5:3]}, b = {d[2:0], d[2:1]}.
- Composite: if the delayed in_win = 1 and not (key_en and mem_data == key), use the expanded pixel; otherwise use the background.
- out_rgb is forced to 0 whenever out_den = 0.

## Timing
- Pipeline stages:
  - Stage 1 (edge 1): register in_win, background and strobes; drive mem_addr.
  - Stage 2 (edge 2): RAM samples the address; the strobes advance.
  - Stage 3 (edge 3): mem_data is composited and out_* are registered.
- Fixed latency is 3 cycles from in_* to out_*, for both window and background pixels.
- out_hs, out_vs and out_den are exactly in_* delayed by 3 cycles, glitch-free.
- No stalls and no back-pressure; one pixel per cycle.
- Reset:
  - Clears all pipeline registers: out_rgb = 0, out_den = out_hs = out_vs = 0, mem_addr = 0.
  - Shadow registers reset to x0 = y0 = 0, scale = 0, bg_mode = 0, bg_color = 0, key_en = 0, key = 0.
- Reset mid-frame: outputs stay 0 for 3 cycles after rst deasserts. Output then resumes from live inputs using the default shadow values until the next frame_start.
- frame_start mid-line is legal; the new config applies from the next cycle's pixel with no pipeline flush.

## Test plan
- Reset then idle: rst = 1 for 4 cycles with in_den = 1 → all out_* = 0 during reset and for 3 cycles after release.
- Latency: frame_start with x0 = y0 = 16, scale = 2; drive x = 16, y = 16, den = 1.
  - Expect mem_addr = 0 at edge 1.
  - With mem_data = 9'h1FF, expect out_rgb = 16'hFFFF at edge 3.
  - x = 20 → mem_addr col = 1; x = 19 → col = 0.
- Window edge: scale = 2, x0 = 16, 64 columns → x = 271 is in-window (col 63); x = 272 gives the background.
  - Clip check: x0 = 16'hFFF0 → no in-window pixels at x < x0, and none past the top of the x range.
- Background modes: x = 3, y = 5 outside the window.
  - mode 1 → out_rgb = 8.
  - mode 2 with bg_color = 16'h001F, x = 8, y = 0 → 16'h001F; x = 8, y = 8 → 16'hFFE0.
  - mode 3 → 0.
- Transparency and FMT 1: key_en = 1, key = 9'h000, mem_data = 0 → background. mem_data = 9'b111000000 → out_rgb = 16'h001F.
- Shadow timing: change cfg_x0 without frame_start → no effect. Pulse frame_start concurrently with a pixel → that pixel uses the old x0, and the next pixel uses the new x0.
